// File: rtl/drp_pkg.sv
`default_nettype none
// =============================================================================
// drp_pkg : shared DRP register map, reset constants and FSM state encoding
// Rev 1.0
// =============================================================================
package drp_pkg;

  localparam logic [6:0]  ADDR_TEMP  = 7'h00;
  localparam logic [6:0]  ADDR_VAUX1 = 7'h11;
  localparam logic [6:0]  ADDR_STAT  = 7'h3F;
  localparam logic [6:0]  ADDR_CFG0  = 7'h40;
  localparam logic [6:0]  ADDR_CFG1  = 7'h41;
  localparam logic [6:0]  ADDR_CFG2  = 7'h42;

  localparam logic [15:0] CFG2_RST   = 16'h0400;

  localparam logic [4:0]  CHAN_TEMP  = 5'h00;
  localparam logic [4:0]  CHAN_VAUX1 = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } drp_state_e;

endpackage
`default_nettype wire

// File: rtl/drp_conv_sequencer.sv
`default_nettype none
// =============================================================================
// drp_conv_sequencer : free-running temp/vaux1 conversion timing with halt
// Rev 1.0
// =============================================================================
module drp_conv_sequencer
  import drp_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt_i,
  output logic       busy_o,
  output logic       eoc_o,
  output logic       eos_o,
  output logic [4:0] channel_o,
  output logic       upd_temp_o,
  output logic       upd_vaux1_o
);

  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES);

  logic [7:0] cnt_q;
  logic       ch_q;      // 0: temp, 1: vaux1 (the conversion in flight or next)
  logic       busy_q;
  logic       eoc_q;
  logic       eos_q;
  logic [4:0] chan_q;
  logic       conv_done;

  // Strobes fire in the last busy cycle so the result lands on the eoc edge.
  assign conv_done   = busy_q && (cnt_q == CONV_LAST);
  assign upd_temp_o  = conv_done && !ch_q;
  assign upd_vaux1_o = conv_done &&  ch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      ch_q   <= 1'b0;
      busy_q <= 1'b0;
      eoc_q  <= 1'b0;
      eos_q  <= 1'b0;
      chan_q <= CHAN_TEMP;
    end else begin
      eoc_q <= 1'b0;
      eos_q <= 1'b0;
      if (conv_done) begin
        busy_q <= 1'b0;
        eoc_q  <= 1'b1;
        eos_q  <= ch_q;
        chan_q <= ch_q ? CHAN_VAUX1 : CHAN_TEMP;
        ch_q   <= ~ch_q;
        cnt_q  <= 8'd0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 8'd1;
      end else if (halt_i) begin
        ch_q <= 1'b0;
      end else begin
        busy_q <= 1'b1;
        cnt_q  <= 8'd1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign eoc_o     = eoc_q;
  assign eos_o     = eos_q;
  assign channel_o = chan_q;

endmodule
`default_nettype wire

// File: rtl/drp_sensor_responder.sv
`default_nettype none
// =============================================================================
// drp_sensor_responder : XADC-style DRP register responder with sequencer
// Rev 1.0
// =============================================================================
module drp_sensor_responder
  import drp_pkg::*;
#(
  parameter int DRP_LATENCY = 4,
  parameter int CONV_CYCLES = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  input  logic [11:0] temp_in,
  input  logic [11:0] vaux1_in,
  output logic        busy_out,
  output logic [4:0]  channel_out,
  output logic        eoc_out,
  output logic        eos_out
);

  localparam logic [3:0] LAT_LAST = 4'(DRP_LATENCY - 1);

  drp_state_e  state_q;
  logic [3:0]  lat_q;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic        drdy_q;
  logic [15:0] do_q;

  logic [15:0] temp_q;
  logic [15:0] vaux1_q;
  logic [15:0] cfg0_q;
  logic [15:0] cfg1_q;
  logic [15:0] cfg2_q;
  logic        ovr_q;

  logic        upd_temp;
  logic        upd_vaux1;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;

  drp_conv_sequencer #(
    .CONV_CYCLES (CONV_CYCLES)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .halt_i      (cfg1_q[15]),
    .busy_o      (busy_out),
    .eoc_o       (eoc_out),
    .eos_o       (eos_out),
    .channel_o   (channel_out),
    .upd_temp_o  (upd_temp),
    .upd_vaux1_o (upd_vaux1)
  );

  // A response leaves WAIT using the latched address; a single-cycle latency
  // responds straight from IDLE/RESP, so the live address is used there.
  always_comb begin
    rd_addr = (state_q == ST_WAIT) ? addr_q : daddr_in;
    rd_data = 16'h0000;
    case (rd_addr)
      ADDR_TEMP:  rd_data = temp_q;
      ADDR_VAUX1: rd_data = vaux1_q;
      ADDR_STAT:  rd_data = {15'h0000, ovr_q};
      ADDR_CFG0:  rd_data = cfg0_q;
      ADDR_CFG1:  rd_data = cfg1_q;
      ADDR_CFG2:  rd_data = cfg2_q;
      default:    rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= 4'd0;
      addr_q  <= 7'd0;
      we_q    <= 1'b0;
      di_q    <= 16'h0000;
      drdy_q  <= 1'b0;
      do_q    <= 16'h0000;
    end else begin
      drdy_q <= 1'b0;
      do_q   <= 16'h0000;
      unique case (state_q)
        ST_IDLE, ST_RESP: begin
          if (den_in) begin
            addr_q <= daddr_in;
            we_q   <= dwe_in;
            di_q   <= di_in;
            if (DRP_LATENCY == 1) begin
              state_q <= ST_RESP;
              drdy_q  <= 1'b1;
              do_q    <= dwe_in ? 16'h0000 : rd_data;
            end else begin
              state_q <= ST_WAIT;
              lat_q   <= 4'd1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= ST_RESP;
            drdy_q  <= 1'b1;
            do_q    <= we_q ? 16'h0000 : rd_data;
          end else begin
            lat_q <= lat_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Writes commit at the end of the RESP cycle; result registers are read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q  <= 16'h0000;
      vaux1_q <= 16'h0000;
      cfg0_q  <= 16'h0000;
      cfg1_q  <= 16'h0000;
      cfg2_q  <= CFG2_RST;
      ovr_q   <= 1'b0;
    end else begin
      if (upd_temp)  temp_q  <= {temp_in, 4'h0};
      if (upd_vaux1) vaux1_q <= {vaux1_in, 4'h0};
      if (den_in && state_q == ST_WAIT) ovr_q <= 1'b1;
      if (state_q == ST_RESP && we_q) begin
        case (addr_q)
          ADDR_STAT: ovr_q  <= 1'b0;
          ADDR_CFG0: cfg0_q <= di_q;
          ADDR_CFG1: cfg1_q <= di_q;
          ADDR_CFG2: cfg2_q <= di_q;
          default: ;
        endcase
      end
    end
  end

  assign drdy_out = drdy_q;
  assign do_out   = do_q;

endmodule
`default_nettype wire

// File: tb/tb_drp_sensor_responder.sv
`default_nettype none
// =============================================================================
// tb_drp_sensor_responder : randomized self-checking bench with timeline model
// Rev 1.0
// =============================================================================
module tb_drp_sensor_responder;
  import drp_pkg::*;

  localparam int L = 4;
  localparam int C = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  daddr_in;
  logic        den_in;
  logic        dwe_in;
  logic [15:0] di_in;
  logic [15:0] do_out;
  logic        drdy_out;
  logic [11:0] temp_in;
  logic [11:0] vaux1_in;
  logic        busy_out;
  logic [4:0]  channel_out;
  logic        eoc_out;
  logic        eos_out;

  int checks = 0;
  int errors = 0;

  drp_sensor_responder #(.DRP_LATENCY(L), .CONV_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .daddr_in(daddr_in), .den_in(den_in), .dwe_in(dwe_in),
    .di_in(di_in), .do_out(do_out), .drdy_out(drdy_out), .temp_in(temp_in),
    .vaux1_in(vaux1_in), .busy_out(busy_out), .channel_out(channel_out),
    .eoc_out(eoc_out), .eos_out(eos_out)
  );

  always #5 clk = ~clk;

  // Reference model: transactions and conversions tracked as absolute edge
  // timestamps; expected outputs describe the cycle after each edge.
  int          cyc = 0;
  logic [15:0] m_temp, m_vaux, m_cfg0, m_cfg1, m_cfg2;
  bit          m_ovr;
  bit          p_valid, p_we;
  logic [6:0]  p_addr;
  logic [15:0] p_di;
  int          p_resp;
  bit          s_idle, s_ch;
  int          s_eoc_at;
  bit          w_pend, ovr_hit;
  logic [6:0]  w_addr;
  logic [15:0] w_data;
  logic        e_drdy, e_busy, e_eoc, e_eos;
  logic [15:0] e_do;
  logic [4:0]  e_chan;
  logic [24:0] obs, mexp;

  assign obs  = {drdy_out, do_out, busy_out, eoc_out, eos_out, channel_out};
  assign mexp = {e_drdy, e_do, e_busy, e_eoc, e_eos, e_chan};

  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      ADDR_TEMP:  return m_temp;
      ADDR_VAUX1: return m_vaux;
      ADDR_STAT:  return {15'h0000, m_ovr};
      ADDR_CFG0:  return m_cfg0;
      ADDR_CFG1:  return m_cfg1;
      ADDR_CFG2:  return m_cfg2;
      default:    return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_temp = 16'h0000; m_vaux = 16'h0000; m_cfg0 = 16'h0000;
      m_cfg1 = 16'h0000; m_cfg2 = 16'h0400; m_ovr = 1'b0;
      p_valid = 1'b0; s_idle = 1'b1; s_ch = 1'b0;
      e_drdy = 1'b0; e_do = 16'h0000; e_busy = 1'b0;
      e_eoc = 1'b0; e_eos = 1'b0; e_chan = 5'h00;
    end else begin
      w_pend = 1'b0; ovr_hit = 1'b0;
      if (p_valid && p_resp == cyc - 1) begin
        w_pend = p_we; w_addr = p_addr; w_data = p_di; p_valid = 1'b0;
      end
      if (den_in) begin
        if (!p_valid) begin
          p_valid = 1'b1; p_addr = daddr_in; p_we = dwe_in; p_di = di_in;
          p_resp = cyc + L - 1;
        end else begin
          ovr_hit = 1'b1;
        end
      end
      e_drdy = p_valid && (p_resp == cyc);
      e_do   = (e_drdy && !p_we) ? m_read(p_addr) : 16'h0000;
      e_eoc = 1'b0; e_eos = 1'b0;
      if (!s_idle) begin
        if (cyc == s_eoc_at) begin
          if (s_ch) m_vaux = {vaux1_in, 4'h0};
          else      m_temp = {temp_in, 4'h0};
          e_eoc = 1'b1; e_eos = s_ch; e_chan = s_ch ? 5'h11 : 5'h00;
          e_busy = 1'b0; s_ch = !s_ch; s_idle = 1'b1;
        end
      end else if (m_cfg1[15]) begin
        s_ch = 1'b0;
      end else begin
        s_idle = 1'b0; s_eoc_at = cyc + C; e_busy = 1'b1;
      end
      if (ovr_hit) m_ovr = 1'b1;
      if (w_pend) begin
        case (w_addr)
          ADDR_STAT: m_ovr  = 1'b0;
          ADDR_CFG0: m_cfg0 = w_data;
          ADDR_CFG1: m_cfg1 = w_data;
          ADDR_CFG2: m_cfg2 = w_data;
          default: ;
        endcase
      end
    end
  end

  // One DRP request, then watch 8 cycles; returns DUT data, model data,
  // the cycle of the first drdy and the number of drdy pulses.
  task automatic drp_txn(input logic [6:0] a, input bit we, input logic [15:0] d,
                         output logic [15:0] rdata, output logic [15:0] mdata,
                         output int lat, output int n);
    lat = 0; n = 0; rdata = 16'h0000; mdata = 16'h0000;
    @(negedge clk);
    den_in = 1'b1; daddr_in = a; dwe_in = we; di_in = d;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      den_in = 1'b0;
      if (drdy_out) begin
        n++;
        if (lat == 0) begin lat = j; rdata = do_out; mdata = e_do; end
      end
    end
  endtask

  task automatic test_reset();
    int first, lat, n;
    logic [15:0] rd, md;
    rst = 1'b1; den_in = 1'b0; daddr_in = 7'h00; dwe_in = 1'b0; di_in = 16'h0000;
    temp_in = 12'hABC; vaux1_in = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs, 25'd0);
    end
    rst = 1'b0; first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL reset_model k=%0d got=%h want=%h", k, obs, mexp); end
      if (eoc_out) first = k;
    end
    checks++;
    if (first != C + 1 || channel_out !== 5'h00) begin
      errors++; $display("FAIL first_eoc cycle=%0d ch=%h want cycle=%0d ch=00", first, channel_out, C + 1);
    end
    drp_txn(ADDR_TEMP, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (lat != L || n != 1) begin errors++; $display("FAIL temp_latency lat=%0d n=%0d want lat=%0d n=1", lat, n, L); end
    checks++;
    if (rd !== 16'hABC0 || md !== 16'hABC0) begin
      errors++; $display("FAIL temp_read got=%h model=%h want=abc0", rd, md);
    end
  endtask

  task automatic test_held_den();
    int prev, good;
    bit eos_seen;
    prev = 0; good = 0; eos_seen = 1'b0;
    vaux1_in = 12'hFFF;
    @(negedge clk);
    den_in = 1'b1; daddr_in = ADDR_VAUX1; dwe_in = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL held_model k=%0d got=%h want=%h", k, obs, mexp); end
      if (drdy_out) begin
        checks++;
        if (k - prev != L) begin errors++; $display("FAIL held_period gap=%0d want=%0d", k - prev, L); end
        prev = k;
        if (eos_seen) begin
          checks++; good++;
          if (do_out !== 16'hFFF0) begin errors++; $display("FAIL held_data got=%h want=fff0", do_out); end
        end
      end
      if (eos_out) eos_seen = 1'b1;
    end
    den_in = 1'b0;
    checks++;
    if (good == 0) begin errors++; $display("FAIL held_post_eos reads=%0d want>0", good); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL held_drain got=%h want=%h", obs, mexp); end
    end
  endtask

  task automatic test_write_readback();
    int lat, n;
    logic [15:0] rd, md, d;
    drp_txn(ADDR_CFG0, 1'b1, 16'h1234, rd, md, lat, n);
    checks++;
    if (lat != L || n != 1 || rd !== 16'h0000) begin
      errors++; $display("FAIL cfg0_write lat=%0d n=%0d do=%h want lat=%0d n=1 do=0000", lat, n, rd, L);
    end
    drp_txn(ADDR_CFG0, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'h1234 || md !== 16'h1234) begin errors++; $display("FAIL cfg0_read got=%h model=%h want=1234", rd, md); end
    drp_txn(ADDR_VAUX1, 1'b1, 16'h5555, rd, md, lat, n);
    drp_txn(ADDR_VAUX1, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'hFFF0 || md !== 16'hFFF0) begin errors++; $display("FAIL vaux1_ro got=%h model=%h want=fff0", rd, md); end
    d = 16'($urandom);
    drp_txn(ADDR_CFG2, 1'b1, d, rd, md, lat, n);
    drp_txn(ADDR_CFG2, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== d || md !== d) begin errors++; $display("FAIL cfg2_read got=%h model=%h want=%h", rd, md, d); end
    drp_txn(7'h25, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'h0000 || lat != L) begin errors++; $display("FAIL unmapped_read got=%h lat=%0d want=0000 lat=%0d", rd, lat, L); end
  endtask

  task automatic test_overrun();
    int lat, n, pos, cnt;
    logic [15:0] rd, md, got;
    pos = 0; cnt = 0; got = 16'h0000;
    @(negedge clk);
    den_in = 1'b1; daddr_in = ADDR_CFG0; dwe_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) daddr_in = ADDR_VAUX1;
      else den_in = 1'b0;
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL overrun_model k=%0d got=%h want=%h", k, obs, mexp); end
      if (drdy_out) begin cnt++; pos = k; got = do_out; end
    end
    checks++;
    if (cnt != 1 || pos != L || got !== 16'h1234) begin
      errors++; $display("FAIL overrun_resp n=%0d at=%0d do=%h want n=1 at=%0d do=1234", cnt, pos, got, L);
    end
    drp_txn(ADDR_STAT, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'h0001 || md !== 16'h0001) begin errors++; $display("FAIL status_set got=%h model=%h want=0001", rd, md); end
    drp_txn(ADDR_STAT, 1'b1, 16'($urandom), rd, md, lat, n);
    drp_txn(ADDR_STAT, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'h0000 || md !== 16'h0000) begin errors++; $display("FAIL status_clear got=%h model=%h want=0000", rd, md); end
  endtask

  task automatic test_halt();
    int lat, n;
    bit seen;
    logic [15:0] rd, md;
    seen = 1'b0;
    for (int k = 0; k < 70 && !seen; k++) begin
      @(negedge clk);
      if (eos_out) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL halt_align eos=0 want=1"); end
    repeat (5) @(negedge clk);
    drp_txn(ADDR_CFG1, 1'b1, 16'h8000, rd, md, lat, n);
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL halt_midconv busy=%b want=1", busy_out); end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL halt_model got=%h want=%h", obs, mexp); end
      if (eoc_out) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL halt_final_eoc eoc=0 want=1"); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if (busy_out !== 1'b0 || eoc_out !== 1'b0 || obs !== mexp) begin
        errors++; $display("FAIL halt_idle busy=%b eoc=%b got=%h want=%h", busy_out, eoc_out, obs, mexp);
      end
    end
    drp_txn(ADDR_CFG1, 1'b1, 16'h0000, rd, md, lat, n);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL restart_model got=%h want=%h", obs, mexp); end
      if (eoc_out) seen = 1'b1;
    end
    checks++;
    if (!seen || channel_out !== 5'h00) begin
      errors++; $display("FAIL restart_channel eoc=%b ch=%h want eoc=1 ch=00", seen, channel_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    logic [15:0] rd, md;
    drp_txn(ADDR_CFG2, 1'b1, 16'h0400 ^ 16'($urandom_range(1, 65535)), rd, md, lat, n);
    @(negedge clk);
    den_in = 1'b1; daddr_in = ADDR_CFG2; dwe_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      den_in = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      checks++;
      if (drdy_out !== 1'b0 || obs !== mexp) begin
        errors++; $display("FAIL reset_mid k=%0d drdy=%b got=%h want=%h", k, drdy_out, obs, mexp);
      end
    end
    drp_txn(ADDR_CFG2, 1'b0, 16'h0000, rd, md, lat, n);
    checks++;
    if (rd !== 16'h0400 || md !== 16'h0400) begin errors++; $display("FAIL cfg2_reset got=%h model=%h want=0400", rd, md); end
  endtask

  task automatic test_random();
    logic [6:0] addr_tab [6] = '{ADDR_TEMP, ADDR_VAUX1, ADDR_STAT, ADDR_CFG0, ADDR_CFG1, ADDR_CFG2};
    int sel;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL random_model k=%0d got=%h want=%h", k, obs, mexp); end
      temp_in  = 12'($urandom);
      vaux1_in = 12'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      den_in   = ($urandom_range(0, 2) == 0);
      sel      = $urandom_range(0, 6);
      daddr_in = (sel == 6) ? 7'($urandom) : addr_tab[sel];
      dwe_in   = 1'($urandom_range(0, 1));
      di_in    = 16'($urandom);
    end
    rst = 1'b0; den_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL random_drain got=%h want=%h", obs, mexp); end
    end
  endtask

  initial begin
    test_reset();
    test_held_den();
    test_write_readback();
    test_overrun();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/drp_sensor_responder.md
# drp_sensor_responder

Synthesizable DRP responder that emulates the register side of the XADC dynamic reconfiguration port, so DRP initiators (the ADC display path and its successors) can be simulated and run on the EGo1 without the hard XADC primitive. It runs a free-running two-channel conversion sequencer over 12-bit digital sample inputs. It answers DRP reads and writes with a fixed, parameterized latency and presents results left-justified in 16-bit registers, exactly as the XADC does.

## Interface
- DRP_LATENCY, 4, cycles from den_in acceptance to drdy_out pulse; legal range 1..15
- CONV_CYCLES, 26, cycles per conversion; legal range 4..255
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- daddr_in  in  7  DRP register address
- den_in  in  1  DRP enable, one-cycle request strobe
- dwe_in  in  1  DRP write enable, qualified by den_in
- di_in  in  16  DRP write data
- do_out  out  16  DRP read data, valid only while drdy_out=1
- drdy_out  out  1  DRP completion pulse, one cycle
- temp_in  in  12  sample source for channel 0x00
- vaux1_in  in  12  sample source for channel 0x11
- busy_out  out  1  conversion in progress
- channel_out  out  5  channel of the most recent completed conversion
- eoc_out  out  1  end-of-conversion pulse
- eos_out  out  1  end-of-sequence pulse

## Operation
- Register map:
  - 0x00 temp result, read-only.
  - 0x11 vaux1 result, read-only.
  - 0x3F status: bit0 sticky overrun, other bits 0; any write clears it.
  - 0x40 cfg0, R/W.
  - 0x41 cfg1, R/W; bit15=1 halts the sequencer.
  - 0x42 cfg2, R/W.
  - All other addresses read 0x0000; writes to them and to result registers are ignored.
- Reset values: results 0x0000, cfg0 0x0000, cfg1 0x0000, cfg2 0x0400, status 0x0000.
- Results are stored as {sample[11:0], 4'h0}.
- DRP FSM states:
  - IDLE: den_in=1 latches addr, we and di, then goes to WAIT.
  - WAIT: counts DRP_LATENCY-1 cycles, then goes to RESP.
  - RESP: drdy_out=1 for one cycle; returns to IDLE, or to WAIT if den_in=1 in this cycle.
- den_in is accepted in IDLE and in RESP. den_in=1 in WAIT is ignored (not queued) and sets status bit0.
- Reads: do_out carries the register contents at the start of the RESP cycle, i.e. the pre-update value if a result update hits the same edge.
- Writes: applied on the RESP cycle. do_out=0x0000 for writes and whenever drdy_out=0.
- Conversion sequencer:
  - Order is channel 0x00 then 0x11, repeating.
  - Each conversion is CONV_CYCLES cycles with busy_out=1.
  - The input is sampled on the last conversion cycle and written to the result register.
  - The next cycle has busy_out=0, eoc_out=1 and channel_out set to that channel. eos_out=1 in the same cycle when the channel is 0x11.
  - The next conversion then starts.
- Halt: setting cfg1[15] lets the current conversion finish (with eoc), then the sequencer idles with busy_out=0. Clearing cfg1[15] restarts at channel 0x00.

## Timing
- All outputs are registered. After rst, every output is 0 and channel_out=0.
- The first conversion begins in the first cycle after rst deasserts. The first eoc_out appears CONV_CYCLES+1 cycles after rst deasserts.
- den_in sampled at edge T gives drdy_out high in cycle T+DRP_LATENCY.
- A den_in held high continuously yields one transaction every DRP_LATENCY cycles. Each den after the first is captured in a RESP cycle.
- rst mid-transaction drops the pending access (no drdy_out) and mid-conversion aborts the conversion (no eoc_out); registers return to reset values.
- Counter widths: 4-bit latency counter, 8-bit conversion counter; neither wraps past its terminal count.

## Structure
- Shared package drp_pkg holds:
  - address constants ADDR_TEMP=7'h00, ADDR_VAUX1=7'h11, ADDR_STAT=7'h3F, ADDR_CFG0..2=7'h40..42;
  - the CFG2 reset constant;
  - the DRP FSM state encoding.
- One sub-module, drp_conv_sequencer, owns the conversion counter, channel toggle, halt logic, eoc/eos/busy and result update strobes. The top owns the DRP FSM and the register file.

## Test plan
- Reset release, temp_in=12'hABC: eoc_out at cycle 27 with channel_out=0x00. A read of 0x00 returns 0xABC0 with drdy_out 4 cycles after den_in.
- vaux1_in=12'hFFF, den_in held high at address 0x11: drdy_out every 4 cycles. Once the second eoc (eos_out=1) has passed, do_out=0xFFF0.
- Write 0x1234 to 0x40 and read it back → 0x1234. Write 0x5555 to 0x11 → a later read still returns the sampled value.
- den_in pulsed at T and again at T+1 → one drdy_out only, at T+4, and a read of 0x3F returns 0x0001. Any write to 0x3F clears it to 0x0000.
- Write cfg1=0x8000 mid-conversion → the current conversion ends with eoc_out, then busy_out stays 0. Write 0x0000 → the next eoc_out has channel_out=0x00.
- Assert rst for 1 cycle during the WAIT state → no drdy_out. A read of 0x42 returns 0x0400.
